// File: rtl/coin_pkg.sv
// Shared types and constants for the coin input front-end.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT_REL
    } coin_state_t;

    typedef logic [1:0] coin_val_t;

    localparam coin_val_t COIN_NONE = 2'd0;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer; the output flips only
// after CYCLES consecutive cycles of disagreement with the current debounced state.
module debouncer #(
    parameter int unsigned CYCLES  = 500000,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int unsigned   CW   = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1  <= RST_VAL;
            r_s2  <= RST_VAL;
            r_deb <= RST_VAL;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                // This edge is the CYCLES-th consecutive mismatch.
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns the raw coin button and selector into a clean CoinValue/CoinInserted pair,
// rejecting empty selections and counting accepted coins.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_CYCLES    = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       coinButton,
    input  logic [1:0] coinSel,
    output logic [1:0] CoinValue,
    output logic       CoinInserted,
    output logic       coinRejected,
    output logic       busy,
    output logic [7:0] coinsAccepted
);

    localparam int unsigned   PW         = $clog2(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    logic          w_deb;
    logic          r_deb_prev;
    logic          w_deb_rise;
    coin_val_t     r_sel_s1;
    coin_val_t     r_sel_s2;
    coin_val_t     r_coin_value;
    coin_state_t   r_state;
    coin_state_t   w_state_next;
    logic [PW-1:0] r_pulse_cnt;
    logic          r_rejected;
    logic [7:0]    r_coins;
    logic          w_latch;
    logic          w_reject;

    debouncer #(
        .CYCLES  (DEBOUNCE_CYCLES),
        .RST_VAL (1'b1)
    ) u_btn_deb (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_raw (coinButton),
        .o_deb (w_deb)
    );

    // Previous state resets to pressed so a button held through reset never looks like a rise.
    assign w_deb_rise = w_deb & ~r_deb_prev;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_REL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_reject     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_deb_rise) begin
                    if (r_sel_s2 != COIN_NONE) begin
                        w_latch      = 1'b1;
                        w_state_next = SETUP;
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = WAIT_REL;
                    end
                end
            end
            SETUP:    w_state_next = PULSE;
            PULSE: begin
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!w_deb) begin
                    w_state_next = IDLE;
                end
            end
            default:  w_state_next = WAIT_REL;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sel_s1     <= COIN_NONE;
            r_sel_s2     <= COIN_NONE;
            r_deb_prev   <= 1'b1;
            r_coin_value <= COIN_NONE;
            r_rejected   <= 1'b0;
            r_pulse_cnt  <= '0;
            r_coins      <= '0;
        end else begin
            r_sel_s1   <= coinSel;
            r_sel_s2   <= r_sel_s1;
            r_deb_prev <= w_deb;
            r_rejected <= w_reject;
            if (w_latch) begin
                r_coin_value <= r_sel_s2;
            end
            if (r_state == SETUP) begin
                r_pulse_cnt <= '0;
                if (r_coins != 8'hFF) begin
                    r_coins <= r_coins + 8'd1;
                end
            end else if (r_state == PULSE) begin
                r_pulse_cnt <= r_pulse_cnt + PW'(1);
            end
        end
    end

    // Decoded straight from state so an asynchronous reset drops the pulse at once.
    assign CoinInserted  = (r_state == PULSE);
    assign busy          = (r_state != IDLE);
    assign CoinValue     = r_coin_value;
    assign coinRejected  = r_rejected;
    assign coinsAccepted = r_coins;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with D = 4, P = 3: a cycle table for
// press/release/reject, plus sequences for bounce, held reset, saturation and mid-pulse reset.
module tb_coin_input_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned P = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [1:0] sel;
    logic [1:0] val;
    logic       ins;
    logic       rej;
    logic       busy;
    logic [7:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       btn;
        logic [1:0] sel;
        logic [1:0] val;
        logic       ins;
        logic       rej;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst),
        .coinButton    (btn),
        .coinSel       (sel),
        .CoinValue     (val),
        .CoinInserted  (ins),
        .coinRejected  (rej),
        .busy          (busy),
        .coinsAccepted (cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int n, input logic b, input logic [1:0] s, input logic [1:0] v,
                        input logic i, input logic r, input logic bz, input logic [7:0] c);
        vec_t x;
        x.btn  = b;
        x.sel  = s;
        x.val  = v;
        x.ins  = i;
        x.rej  = r;
        x.busy = bz;
        x.cnt  = c;
        for (int k = 0; k < n; k++) vecs.push_back(x);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk(name, 8'(busy), 8'd0);
    endtask

    // Ticks n cycles from the current inputs; reports first cycle with a pulse and its width.
    task automatic observe(input int n, output int first, output int width);
        first = -1;
        width = 0;
        for (int e = 0; e < n; e++) begin
            tick();
            if (ins) begin
                if (first < 0) first = e;
                width++;
            end
        end
    endtask

    task automatic do_coin();
        btn = 1'b1;
        sel = 2'd1;
        repeat (11) tick();
        btn = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first;
        int width;
        int bad;

        rst = 1'b1;
        btn = 1'b0;
        sel = 2'd0;
        repeat (2) tick();
        chk("reset val", 8'(val), 8'd0);
        chk("reset ins", 8'(ins), 8'd0);
        chk("reset rej", 8'(rej), 8'd0);
        chk("reset busy", 8'(busy), 8'd1);
        chk("reset cnt", cnt, 8'd0);

        rst = 1'b0;
        repeat (6) tick();
        chk("busy before release settles", 8'(busy), 8'd1);
        tick();
        chk("busy falls after 2+D+1", 8'(busy), 8'd0);

        // Clean press sel=2; selector changes after the latch edge must be ignored.
        fill(6, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        fill(1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0);
        fill(3, 1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1);
        fill(1, 1'b1, 2'd3, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1);
        fill(6, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1);
        fill(1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        // Press with no coin selected: one-cycle reject, value and count untouched.
        fill(6, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        fill(1, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 8'd1);
        fill(1, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1);
        fill(6, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1);
        fill(1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            btn = vecs[k].btn;
            sel = vecs[k].sel;
            tick();
            chk($sformatf("vec%0d val", k), 8'(val), 8'(vecs[k].val));
            chk($sformatf("vec%0d ins", k), 8'(ins), 8'(vecs[k].ins));
            chk($sformatf("vec%0d rej", k), 8'(rej), 8'(vecs[k].rej));
            chk($sformatf("vec%0d busy", k), 8'(busy), 8'(vecs[k].busy));
            chk($sformatf("vec%0d cnt", k), cnt, vecs[k].cnt);
        end

        // Two 3-cycle bounces must not reach the 4-cycle threshold.
        sel = 2'd3;
        bad = 0;
        repeat (2) begin
            btn = 1'b1;
            repeat (3) begin
                tick();
                if (ins || busy) bad++;
            end
            btn = 1'b0;
            repeat (3) begin
                tick();
                if (ins || busy) bad++;
            end
        end
        chk("bounce no activity", 8'(bad), 8'd0);
        btn = 1'b1;
        observe(15, first, width);
        chk("bounce rise edge", 8'(first), 8'(D + 3));
        chk("bounce pulse width", 8'(width), 8'(P));
        chk("bounce val", 8'(val), 8'd3);
        chk("bounce cnt", cnt, 8'd2);
        btn = 1'b0;
        wait_idle("bounce release idle", 12);

        // Button held through reset release is never credited.
        btn = 1'b1;
        sel = 2'd2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (ins || !busy) bad++;
        end
        chk("held reset no pulse", 8'(bad), 8'd0);
        chk("held reset cnt", cnt, 8'd0);
        btn = 1'b0;
        wait_idle("held reset release idle", 10);
        btn = 1'b1;
        sel = 2'd1;
        observe(15, first, width);
        chk("after held rise edge", 8'(first), 8'(D + 3));
        chk("after held width", 8'(width), 8'(P));
        chk("after held cnt", cnt, 8'd1);
        chk("after held val", 8'(val), 8'd1);
        btn = 1'b0;
        wait_idle("after held idle", 12);

        // Saturation: 254 more coins reach 255, two more stay there.
        repeat (254) do_coin();
        chk("cnt reaches 255", cnt, 8'd255);
        repeat (2) do_coin();
        chk("cnt saturates", cnt, 8'd255);
        chk("idle after sat", 8'(busy), 8'd0);

        // Reset asserted mid-pulse.
        btn = 1'b1;
        sel = 2'd2;
        repeat (8) tick();
        chk("mid pulse ins high", 8'(ins), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid reset ins", 8'(ins), 8'd0);
        chk("mid reset cnt", cnt, 8'd0);
        chk("mid reset busy", 8'(busy), 8'd1);
        chk("mid reset val", 8'(val), 8'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        btn = 1'b0;
        observe(20, first, width);
        chk("mid reset no pulse", 8'(width), 8'd0);
        chk("mid reset cnt after", cnt, 8'd0);
        chk("mid reset idle", 8'(busy), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
